// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving NUM_CORES cores serialised access to one single-port synchronous data RAM.
// Each access takes four cycles (IDLE, ISSUE, CAPTURE, ACK); sticky end/protocol status is kept alongside.
module dmem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          req_rd,
    input  logic [NUM_CORES-1:0]          req_wr,
    input  logic [NUM_CORES*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   req_wdata,
    output logic [NUM_CORES-1:0]          ack,
    output logic [DATA_W-1:0]             rdata,
    input  logic [NUM_CORES-1:0]          core_end,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic                          mem_re,
    output logic                          mem_we,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          busy,
    output logic                          all_end,
    output logic                          proto_err,
    output logic [15:0]                   txn_count
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_nx_s;

    logic [NUM_CORES-1:0]   req_s;
    logic [NUM_CORES-1:0]   upper_s;
    logic                   grant_any_s;
    logic [IDX_W-1:0]       grant_idx_s;
    logic [ADDR_W-1:0]      grant_addr_s;
    logic [DATA_W-1:0]      grant_wdata_s;

    logic [IDX_W-1:0]       last_r;
    logic [IDX_W-1:0]       idx_r;
    logic                   op_wr_r;
    logic [NUM_CORES-1:0]   ack_r;
    logic [DATA_W-1:0]      rdata_r;
    logic [ADDR_W-1:0]      mem_addr_r;
    logic [DATA_W-1:0]      mem_wdata_r;
    logic                   mem_re_r;
    logic                   mem_we_r;
    logic                   busy_r;
    logic [NUM_CORES-1:0]   end_seen_r;
    logic                   all_end_r;
    logic                   proto_err_r;
    logic [15:0]            txn_count_r;

    logic [IDX_W-1:0]       last_nx_s;
    logic [IDX_W-1:0]       idx_nx_s;
    logic                   op_wr_nx_s;
    logic [NUM_CORES-1:0]   ack_nx_s;
    logic [DATA_W-1:0]      rdata_nx_s;
    logic [ADDR_W-1:0]      mem_addr_nx_s;
    logic [DATA_W-1:0]      mem_wdata_nx_s;
    logic                   mem_re_nx_s;
    logic                   mem_we_nx_s;
    logic                   busy_nx_s;
    logic                   proto_err_nx_s;
    logic [15:0]            txn_count_nx_s;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_CORES-1:0] v);
        lowest_set = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            lowest_set = v[i] ? IDX_W'(i) : lowest_set;
        end
    endfunction

    // Round-robin search: requesters above the last winner first, otherwise wrap to the lowest requester.
    always_comb begin
        req_s = req_rd | req_wr;
        for (int k = 0; k < NUM_CORES; k++) begin
            upper_s[k] = req_s[k] & (IDX_W'(k) > last_r);
        end
        grant_any_s   = |req_s;
        grant_idx_s   = (|upper_s) ? lowest_set(upper_s) : lowest_set(req_s);
        grant_addr_s  = req_addr[grant_idx_s*ADDR_W +: ADDR_W];
        grant_wdata_s = req_wdata[grant_idx_s*DATA_W +: DATA_W];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: fixed four-cycle walk once a grant is made.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE:    state_nx_s = grant_any_s ? ST_ISSUE : ST_IDLE;
            ST_ISSUE:   state_nx_s = ST_CAPTURE;
            ST_CAPTURE: state_nx_s = ST_ACK;
            ST_ACK:     state_nx_s = ST_IDLE;
            default:    state_nx_s = ST_IDLE;
        endcase
    end

    // Output logic: next values for every registered output and transaction latch.
    always_comb begin
        ack_nx_s       = '0;
        mem_re_nx_s    = 1'b0;
        mem_we_nx_s    = 1'b0;
        busy_nx_s      = (state_nx_s != ST_IDLE);
        rdata_nx_s     = rdata_r;
        mem_addr_nx_s  = mem_addr_r;
        mem_wdata_nx_s = mem_wdata_r;
        txn_count_nx_s = txn_count_r;
        last_nx_s      = last_r;
        idx_nx_s       = idx_r;
        op_wr_nx_s     = op_wr_r;
        proto_err_nx_s = proto_err_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_any_s) begin
                    // The RAM address/data registers double as the transaction latch.
                    idx_nx_s       = grant_idx_s;
                    op_wr_nx_s     = req_wr[grant_idx_s];
                    mem_addr_nx_s  = grant_addr_s;
                    mem_wdata_nx_s = grant_wdata_s;
                    mem_we_nx_s    = req_wr[grant_idx_s];
                    mem_re_nx_s    = ~req_wr[grant_idx_s];
                    proto_err_nx_s = proto_err_r | (req_rd[grant_idx_s] & req_wr[grant_idx_s]);
                end else begin
                    idx_nx_s = idx_r;
                end
            end
            ST_ISSUE: begin
            end
            ST_CAPTURE: begin
                rdata_nx_s = op_wr_r ? rdata_r : mem_rdata;
                ack_nx_s   = {{(NUM_CORES-1){1'b0}}, 1'b1} << idx_r;
            end
            ST_ACK: begin
                last_nx_s      = idx_r;
                txn_count_nx_s = txn_count_r + 16'd1;
            end
            default: begin
                busy_nx_s = 1'b0;
            end
        endcase
    end

    // Output and latch registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_r       <= '0;
            rdata_r     <= '0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_re_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            busy_r      <= 1'b0;
            proto_err_r <= 1'b0;
            txn_count_r <= 16'd0;
            last_r      <= IDX_W'(NUM_CORES - 1);
            idx_r       <= '0;
            op_wr_r     <= 1'b0;
        end else begin
            ack_r       <= ack_nx_s;
            rdata_r     <= rdata_nx_s;
            mem_addr_r  <= mem_addr_nx_s;
            mem_wdata_r <= mem_wdata_nx_s;
            mem_re_r    <= mem_re_nx_s;
            mem_we_r    <= mem_we_nx_s;
            busy_r      <= busy_nx_s;
            proto_err_r <= proto_err_nx_s;
            txn_count_r <= txn_count_nx_s;
            last_r      <= last_nx_s;
            idx_r       <= idx_nx_s;
            op_wr_r     <= op_wr_nx_s;
        end
    end

    // Sticky end tracking; all_end rises the cycle after the last core_end bit is seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            end_seen_r <= '0;
            all_end_r  <= 1'b0;
        end else begin
            end_seen_r <= end_seen_r | core_end;
            all_end_r  <= &(end_seen_r | core_end);
        end
    end

    assign ack       = ack_r;
    assign rdata     = rdata_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_re    = mem_re_r;
    assign mem_we    = mem_we_r;
    assign busy      = busy_r;
    assign all_end   = all_end_r;
    assign proto_err = proto_err_r;
    assign txn_count = txn_count_r;

endmodule
